calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4: command FIFO depth in entries; the value SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have a parameter TIMEOUT, default 255: maximum busy cycles allowed while waiting for a result.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: the keypad presents a code.
REQ-006 The block SHALL have port key_code, input, 4 bits: keypad code; 0-9 are digits, A is plus, B is minus, C is multiply, E is result, F is clear, D is no-op.
REQ-007 The block SHALL have port key_ready, output, 1 bit: the block accepts key_code on this cycle.
REQ-008 The block SHALL have port calc_cmd, output, 4 bits: command driven into the calculator datapath.
REQ-009 The block SHALL have port calc_status, input, 2 bits: calculator status; 0 is idle, 1 is busy, 2 is error.
REQ-010 The block SHALL have port calc_data, input, 4 bits: calculator result digit.
REQ-011 The block SHALL have port res_valid, output, 1 bit: one-cycle pulse marking a captured result.
REQ-012 The block SHALL have port res_digit, output, 4 bits: captured result digit, held until the next capture.
REQ-013 The block SHALL have port err, output, 1 bit: sticky error flag.
REQ-014 The block SHALL have port fifo_count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 The block SHALL drive key_ready as (fifo_count < DEPTH) and (state is not ERROR and not CLEAR), combinationally.
REQ-016 A push SHALL occur when key_valid and key_ready are both high; code D SHALL be accepted but not stored, and every other code SHALL be written to the FIFO tail.
REQ-017 When a push and a pop occur in the same cycle, fifo_count SHALL stay unchanged, and the pushed entry SHALL go behind the popped one.
REQ-018 The state machine SHALL have the states IDLE, ISSUE, GAP, WAIT_RES, ERROR and CLEAR.
REQ-019 When the state is IDLE, the FIFO is non-empty and calc_status is 0, the block SHALL pop the head, register it onto calc_cmd and go to ISSUE.
REQ-020 In ISSUE, calc_cmd SHALL hold the popped code for exactly one cycle; if the code is E, the next state SHALL be WAIT_RES, otherwise GAP.
REQ-021 In every state other than ISSUE and CLEAR, calc_cmd SHALL be D (no-op).
REQ-022 GAP SHALL last exactly one cycle and then return to IDLE, so that issued commands are always separated by at least one no-op cycle.
REQ-023 WAIT_RES SHALL keep an 8-bit busy counter, cleared on entry; the first cycle in WAIT_RES SHALL ignore calc_status to cover the datapath settling.
REQ-024 From the second WAIT_RES cycle on, calc_status of 1 SHALL increment the counter, and reaching TIMEOUT SHALL move the state to ERROR.
REQ-025 From the second WAIT_RES cycle on, calc_status of 0 SHALL load calc_data into res_digit, pulse res_valid for one cycle and move the state to GAP.
REQ-026 calc_status of 2 observed in IDLE, GAP or WAIT_RES SHALL move the state to ERROR on the next edge.
REQ-027 ERROR SHALL set err, empty the FIFO (fifo_count becomes 0) and move to CLEAR after exactly one cycle.
REQ-028 CLEAR SHALL drive calc_cmd F for one cycle and then go to GAP.
REQ-029 err SHALL stay set until the first push accepted after CLEAR, and SHALL clear on that push's edge.
REQ-030 A popped F code SHALL be issued like any other command; it SHALL NOT flush the FIFO and SHALL NOT clear err.
REQ-031 FIFO read and write pointers SHALL wrap modulo DEPTH, and full and empty SHALL be decided from fifo_count.

Reset
REQ-032 While reset is low, the block SHALL hold: state IDLE, FIFO empty, fifo_count 0, calc_cmd D, res_valid 0, res_digit 0, err 0, busy counter 0.
REQ-033 Asserting reset mid-operation, including in WAIT_RES or CLEAR, SHALL abort immediately with no further command issued; key_ready SHALL read 1 right after reset is released.

Verification
REQ-034 Push 3, A, 4, E while calc_status is 0 -> calc_cmd shows 3, A, 4, E, each for 1 cycle with a D cycle between them; res_valid pulses once with res_digit equal to calc_data (7).
REQ-035 Push 6, C, 3, E, then hold calc_status at 1 for 18 cycles and then 0 with calc_data 8 -> res_valid pulses once, res_digit is 8, err stays 0.
REQ-036 Push E with calc_status stuck at 1 -> after TIMEOUT (255) busy cycles the state goes ERROR, err is 1, calc_cmd is F for 1 cycle, fifo_count is 0.
REQ-037 Push 5 entries with DEPTH 4 and calc_status held at 1 -> the 5th push sees key_ready 0, fifo_count stays 4, and no pointer wraps wrongly after draining.
REQ-038 Push a D code and a valid digit in a simultaneous push/pop cycle -> D is not stored, fifo_count stays correct, and ordering is preserved.
REQ-039 Assert reset low during WAIT_RES -> all outputs take their REQ-032 values asynchronously, and no res_valid pulse follows the release.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keypad-to-calculator command sequencer: buffers key codes in a small FIFO,
// issues them one at a time with a no-op gap, and captures results with a busy timeout.
module calc_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   key_valid_i,
  input  logic [3:0]             key_code_i,
  output logic                   key_ready_o,
  output logic [3:0]             calc_cmd_o,
  input  logic [1:0]             calc_status_i,
  input  logic [3:0]             calc_data_i,
  output logic                   res_valid_o,
  output logic [3:0]             res_digit_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [8:0]    TIMEOUT_C = 9'(TIMEOUT);
  localparam logic [3:0]    CODE_D    = 4'hD;
  localparam logic [3:0]    CODE_E    = 4'hE;
  localparam logic [3:0]    CODE_F    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_GAP, S_WAIT_RES, S_ERROR, S_CLEAR
  } state_t;

  state_t          state_q;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      busy_q;
  logic            first_q;
  logic [3:0]      cmd_q;
  logic            res_valid_q;
  logic [3:0]      res_digit_q;
  logic            err_q;

  logic            accept, push, pop, goto_err;
  logic [8:0]      busy_inc;

  assign key_ready_o = (count_q < FULL_C) && (state_q != S_ERROR) && (state_q != S_CLEAR);
  assign accept      = key_valid_i && key_ready_o;
  assign push        = accept && (key_code_i != CODE_D);
  assign pop         = (state_q == S_IDLE) && (count_q != '0) && (calc_status_i == 2'd0);
  assign busy_inc    = {1'b0, busy_q} + 9'd1;

  // The first WAIT_RES cycle is blind to status while the datapath settles.
  always_comb begin
    goto_err = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: goto_err = (calc_status_i == 2'd2);
      S_WAIT_RES:    goto_err = !first_q && ((calc_status_i == 2'd2) ||
                                 ((calc_status_i == 2'd1) && (busy_inc >= TIMEOUT_C)));
      default:       goto_err = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= key_code_i;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      first_q     <= 1'b0;
      cmd_q       <= CODE_D;
      res_valid_q <= 1'b0;
      res_digit_q <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (accept) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (goto_err) begin
            state_q <= S_ERROR;
          end else if (pop) begin
            cmd_q   <= mem_q[rd_ptr_q];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd_q   <= CODE_D;
          busy_q  <= '0;
          first_q <= 1'b1;
          state_q <= (cmd_q == CODE_E) ? S_WAIT_RES : S_GAP;
        end
        S_GAP: begin
          state_q <= goto_err ? S_ERROR : S_IDLE;
        end
        S_WAIT_RES: begin
          first_q <= 1'b0;
          if (goto_err) begin
            state_q <= S_ERROR;
          end else if (!first_q && calc_status_i == 2'd1) begin
            busy_q <= busy_inc[7:0];
          end else if (!first_q && calc_status_i == 2'd0) begin
            res_digit_q <= calc_data_i;
            res_valid_q <= 1'b1;
            state_q     <= S_GAP;
          end
        end
        S_ERROR: begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          cmd_q    <= CODE_F;
          state_q  <= S_CLEAR;
        end
        S_CLEAR: begin
          cmd_q   <= CODE_D;
          state_q <= S_GAP;
        end
        default: state_q <= S_IDLE;
      endcase

      if (goto_err) err_q <= 1'b1;
    end
  end

  assign calc_cmd_o   = cmd_q;
  assign res_valid_o  = res_valid_q;
  assign res_digit_o  = res_digit_q;
  assign err_o        = err_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed scenario bench for calc_sequencer; expected values are hand-derived cycle counts and sequences.
module tb_calc_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready;
  logic [3:0] calc_cmd;
  logic [1:0] calc_status = 2'd0;
  logic [3:0] calc_data = 4'h0;
  logic       res_valid;
  logic [3:0] res_digit;
  logic       err;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [3:0] cmd_log[$];
  int         res_pulses = 0;
  int         adj_err = 0;
  logic [3:0] prev_cmd = 4'hD;

  calc_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .key_valid_i(key_valid), .key_code_i(key_code), .key_ready_o(key_ready),
    .calc_cmd_o(calc_cmd), .calc_status_i(calc_status), .calc_data_i(calc_data),
    .res_valid_o(res_valid), .res_digit_o(res_digit), .err_o(err),
    .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;

  // Records every non-no-op command and flags two command cycles in a row.
  always @(posedge clk) begin
    #1;
    if (calc_cmd != 4'hD) begin
      cmd_log.push_back(calc_cmd);
      if (prev_cmd != 4'hD) adj_err++;
    end
    if (res_valid) res_pulses++;
    prev_cmd = calc_cmd;
  end

  task automatic clear_mon();
    cmd_log.delete();
    res_pulses = 0;
    adj_err = 0;
  endtask

  function automatic logic [31:0] log_word();
    logic [31:0] r = '0;
    foreach (cmd_log[i]) r = {r[27:0], cmd_log[i]};
    return r;
  endfunction

  task automatic push_key(input logic [3:0] code, output logic acc);
    key_valid = 1'b1;
    key_code  = code;
    acc       = key_ready;
    @(negedge clk);
    key_valid = 1'b0;
    $display("push code=%h accepted=%0d count=%0d", code, acc, fifo_count);
  endtask

  task automatic wait_cmd(input logic [3:0] code, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (calc_cmd == code) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({calc_cmd, res_valid, res_digit, err, fifo_count} !== {4'hD, 1'b0, 4'h0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h rv=%b rd=%h err=%b cnt=%0d required cmd=D rv=0 rd=0 err=0 cnt=0",
               calc_cmd, res_valid, res_digit, err, fifo_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_key_ready: got %b required 1", key_ready);
    end
  endtask

  task automatic test_basic_add();
    logic acc;
    clear_mon();
    calc_status = 2'd0;
    calc_data   = 4'h7;
    push_key(4'h3, acc);
    push_key(4'hA, acc);
    push_key(4'h4, acc);
    push_key(4'hE, acc);
    repeat (25) @(negedge clk);
    checks++;
    if (cmd_log.size() != 4 || log_word() !== 32'h3A4E) begin
      errors++;
      $display("FAIL add_cmd_seq: got %h (n=%0d) required 3A4E (n=4)", log_word(), cmd_log.size());
    end
    checks++;
    if (adj_err != 0) begin
      errors++;
      $display("FAIL add_noop_gap: got %0d adjacent commands required 0", adj_err);
    end
    checks++;
    if (res_pulses != 1 || res_digit !== 4'h7) begin
      errors++;
      $display("FAIL add_result: got pulses=%0d digit=%h required pulses=1 digit=7", res_pulses, res_digit);
    end
  endtask

  task automatic test_busy_result();
    logic acc;
    bit   ok;
    clear_mon();
    calc_status = 2'd0;
    push_key(4'h6, acc);
    push_key(4'hC, acc);
    push_key(4'h3, acc);
    push_key(4'hE, acc);
    wait_cmd(4'hE, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_wait_E: got no E command required E within bound");
    end
    calc_status = 2'd1;
    repeat (18) @(negedge clk);
    calc_status = 2'd0;
    calc_data   = 4'h8;
    repeat (5) @(negedge clk);
    checks++;
    if (res_pulses != 1 || res_digit !== 4'h8 || err !== 1'b0) begin
      errors++;
      $display("FAIL busy_result: got pulses=%0d digit=%h err=%b required pulses=1 digit=8 err=0",
               res_pulses, res_digit, err);
    end
    checks++;
    if (log_word() !== 32'h6C3E || adj_err != 0) begin
      errors++;
      $display("FAIL busy_cmd_seq: got %h adj=%0d required 6C3E adj=0", log_word(), adj_err);
    end
  endtask

  task automatic test_timeout();
    logic acc;
    bit   ok;
    int   n;
    clear_mon();
    calc_status = 2'd0;
    push_key(4'hE, acc);
    wait_cmd(4'hE, ok);
    calc_status = 2'd1;
    push_key(4'h7, acc);
    push_key(4'h8, acc);
    n = 2;
    while (err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || n != 257) begin
      errors++;
      $display("FAIL timeout_cycles: got err after %0d cycles (E seen=%0d) required 257", n, ok);
    end
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL timeout_pre_flush_count: got %0d required 2", fifo_count);
    end
    @(negedge clk);
    checks++;
    if (calc_cmd !== 4'hF || fifo_count !== 3'd0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got cmd=%h cnt=%0d rdy=%b required cmd=F cnt=0 rdy=0",
               calc_cmd, fifo_count, key_ready);
    end
    @(negedge clk);
    calc_status = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || adj_err != 0 || res_pulses != 0) begin
      errors++;
      $display("FAIL timeout_err_sticky: got err=%b adj=%0d pulses=%0d required err=1 adj=0 pulses=0",
               err, adj_err, res_pulses);
    end
    push_key(4'hD, acc);
    checks++;
    if (acc !== 1'b1 || err !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL noop_clears_err: got acc=%b err=%b cnt=%0d required acc=1 err=0 cnt=0",
               acc, err, fifo_count);
    end
  endtask

  task automatic test_status_error();
    logic acc;
    calc_status = 2'd2;
    @(negedge clk);
    calc_status = 2'd0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL status_err_set: got %b required 1", err);
    end
    @(negedge clk);
    checks++;
    if (calc_cmd !== 4'hF) begin
      errors++;
      $display("FAIL status_err_clear_cmd: got %h required F", calc_cmd);
    end
    repeat (3) @(negedge clk);
    push_key(4'hD, acc);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL status_err_release: got %b required 0", err);
    end
  endtask

  task automatic test_full();
    logic acc;
    logic all_acc = 1'b1;
    clear_mon();
    calc_status = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      push_key(4'(i), acc);
      all_acc &= acc;
    end
    checks++;
    if (all_acc !== 1'b1 || fifo_count !== 3'd4 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: got acc=%b cnt=%0d rdy=%b required acc=1 cnt=4 rdy=0",
               all_acc, fifo_count, key_ready);
    end
    push_key(4'h5, acc);
    checks++;
    if (acc !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_reject: got acc=%b cnt=%0d required acc=0 cnt=4", acc, fifo_count);
    end
    calc_status = 2'd0;
    repeat (20) @(negedge clk);
    checks++;
    if (cmd_log.size() != 4 || log_word() !== 32'h1234 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL full_drain: got %h (n=%0d) cnt=%0d required 1234 (n=4) cnt=0",
               log_word(), cmd_log.size(), fifo_count);
    end
    clear_mon();
    push_key(4'h5, acc);
    push_key(4'h6, acc);
    push_key(4'h7, acc);
    repeat (20) @(negedge clk);
    checks++;
    if (cmd_log.size() != 3 || log_word() !== 32'h567 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_order: got %h (n=%0d) cnt=%0d required 567 (n=3) cnt=0",
               log_word(), cmd_log.size(), fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    clear_mon();
    calc_status = 2'd1;
    push_key(4'h1, acc);
    push_key(4'h2, acc);
    calc_status = 2'd0;
    key_valid   = 1'b1;
    key_code    = 4'hD;
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL pushpop_noop_count: got %0d required 1", fifo_count);
    end
    repeat (2) @(negedge clk);
    push_key(4'h3, acc);
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL pushpop_digit_count: got %0d required 1", fifo_count);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (cmd_log.size() != 3 || log_word() !== 32'h123) begin
      errors++;
      $display("FAIL pushpop_order: got %h (n=%0d) required 123 (n=3)", log_word(), cmd_log.size());
    end
  endtask

  task automatic test_reset_in_wait();
    logic acc;
    bit   ok;
    calc_status = 2'd0;
    push_key(4'hE, acc);
    wait_cmd(4'hE, ok);
    calc_status = 2'd1;
    push_key(4'h1, acc);
    push_key(4'h2, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({calc_cmd, res_valid, res_digit, err, fifo_count, key_ready} !==
        {4'hD, 1'b0, 4'h0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got cmd=%h rv=%b rd=%h err=%b cnt=%0d rdy=%b required cmd=D rv=0 rd=0 err=0 cnt=0 rdy=1",
               calc_cmd, res_valid, res_digit, err, fifo_count, key_ready);
    end
    calc_status = 2'd0;
    calc_data   = 4'h5;
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b required 1", key_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (res_pulses != 0 || cmd_log.size() != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got pulses=%0d cmds=%0d required 0 0", res_pulses, cmd_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_busy_result();
    test_timeout();
    test_status_error();
    test_full();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
